// File: rtl/mem_lsu.sv
// mem_lsu - load/store initiator between the core memory stage and a
// word-only data memory (combinational read, synchronous write, no byte
// enables). Byte/half/word loads are extracted from the addressed word and
// sign/zero-extended; sub-word stores are performed as read-modify-write.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i / ready_o     core request handshake (accept when both high)
//   we_i, size_i        store/load select, access size (00 b, 01 h, 10 w)
//   unsigned_i          zero-extend sub-word loads when set
//   addr_i, wdata_i     byte address, right-aligned store data
//   done_o              one-cycle completion pulse
//   rdata_o, err_o      load result / misaligned-or-illegal flag (with done_o)
//   mem_rw_o            memory write strobe (1 = write)
//   mem_addr_o          word-aligned memory address
//   mem_wdata_o         memory write word
//   mem_rdata_i         combinational memory read word
//
// Build option: define LSU_PIPE_EN to also accept a new request in the
// response cycle, giving back-to-back loads every 2 cycles.

module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Misaligned or illegal-size access: never touches memory.
    function automatic logic op_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed lane out of the memory word and extend it.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] size,
                                                       input logic uns,
                                                       input logic [1:0] lo);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{~uns & b[7]}}, b};
            SZ_HALF: res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the memory word with the store data.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [DATA_W-1:0] wd,
                                                      input logic [1:0] size,
                                                      input logic [1:0] lo);
        logic [DATA_W-1:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[8*lo +: 8] = wd[7:0];
            SZ_HALF: res[16*lo[1] +: 16] = wd[15:0];
            default: res = wd;
        endcase
        return res;
    endfunction

    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lo_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q;
    // Holds the latched store data until ACCESS, then the merged word.
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ready_s;
    logic              accept_s;
    logic              illegal_s;

    // Request acceptance window.
    always_comb begin
`ifdef LSU_PIPE_EN
        ready_s = (state_q == ST_IDLE) || (state_q == ST_RESP);
`else
        ready_s = (state_q == ST_IDLE);
`endif
        accept_s  = req_i & ready_s;
        illegal_s = op_illegal(size_i, addr_i[1:0]);
    end

    // Next-state and memory write strobe decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = illegal_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_q && (size_q != SZ_WORD)) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (accept_s) begin
                    state_d = illegal_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Entering ACCESS only happens on an accept, so the core inputs are
        // still valid here for the word-store case.
        mem_rw_d = ((state_d == ST_ACCESS) && we_i && (size_i == SZ_WORD)) ||
                   (state_d == ST_WRITE);
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lo_q        <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= (state_d == ST_RESP);
            mem_rw_q <= mem_rw_d;
            if (accept_s) begin
                we_q    <= we_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                lo_q    <= addr_i[1:0];
                err_q   <= illegal_s;
                rdata_q <= '0;
                // An illegal request leaves the memory port untouched.
                if (!illegal_s) begin
                    mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                    mem_wdata_q <= wdata_i;
                end
            end
            if (state_q == ST_ACCESS) begin
                if (!we_q) begin
                    rdata_q <= load_extract(mem_rdata_i, size_q, uns_q, lo_q);
                end else if (size_q != SZ_WORD) begin
                    mem_wdata_q <= store_merge(mem_rdata_i, mem_wdata_q, size_q, lo_q);
                end
            end
        end
    end

    assign ready_o     = ready_s;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    // Reset must suppress a write in the very cycle it is asserted.
    assign mem_rw_o    = mem_rw_q & ~rst;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, ready, we, uns, done, err, mem_rw;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .req_i(req), .ready_o(ready), .we_i(we),
        .size_i(size), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
        .done_o(done), .rdata_o(rdata), .err_o(err), .mem_rw_o(mem_rw),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // ---------------- word memory ----------------
    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b0, pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_rw === 1'b1) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0, last_wd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rw === 1'b1) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        bit          ck_rd;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    int          last_done_cyc = 0;
    int          done_cycs[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic exp_done;
                exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                chk("done_o", {31'd0, done}, {31'd0, exp_done});
                if (exp_done) begin
                    chk("err_o", {31'd0, err}, {31'd0, exp_q[0].err});
                    if (exp_q[0].ck_rd) chk("rdata_o", rdata, exp_q[0].rdata);
                    void'(exp_q.pop_front());
                end
                if (done === 1'b1) begin
                    last_rdata    = rdata;
                    last_err      = err;
                    last_done_cyc = cyc;
                    done_cycs.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = a[9:2];
        pl_val = v;
        ref_mem[a[9:2]] = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit expect_done, output int acc);
        int          n;
        int          sh;
        int          lat;
        logic [31:0] word, m, v;
        bit          bad;
        exp_t        e;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1 acc = cyc;
        if (!expect_done) return;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e.err = bad; e.rdata = 32'd0; e.ck_rd = 1'b1;
        if (bad) begin
            lat = 1;
        end else begin
            word = ref_mem[a[9:2]];
            sh   = 8 * int'(a[1:0]);
            m    = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            if (!w) begin
                v = (word >> sh) & m;
                if (!u && ((sz == 2'b00 && v[7]) || (sz == 2'b01 && v[15]))) v = v | ~m;
                e.rdata = v;
                lat = 2;
            end else begin
                ref_mem[a[9:2]] = (word & ~(m << sh)) | ((wd & m) << sh);
                e.ck_rd = 1'b0;
                lat = (sz == 2'b10) ? 2 : 3;
            end
        end
        e.cyc = acc + lat - 1;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    logic [1:0]  ld_sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        ld_u   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ld_a   [4] = '{32'h203, 32'h203, 32'h200, 32'h202};
    logic [31:0] ld_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F22, 32'h0000_80F1};
    logic        er_w   [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  er_sz  [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] er_a   [3] = '{32'h105, 32'h103, 32'h100};

    initial begin
        int acc;
        int w0;
        int accs[4];
        int gap;
`ifdef LSU_PIPE_EN
        gap = 2;
`else
        gap = 3;
`endif
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk_en = 1'b1;

        // word store then word load
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, acc);
        drain();
        chk("sw_writes", wr_cnt - w0, 32'd1);
        chk("sw_addr", last_wa, 32'h100);
        chk("sw_data", last_wd, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1, acc);
        drain();
        chk("lw_latency", last_done_cyc - acc + 1, 32'd2);
        chk("lw_data", last_rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, last_err}, 32'd0);

        // sub-word loads with extension
        preload(32'h200, 32'h80F1_7F22);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, ld_sz[i], ld_u[i], ld_a[i], 32'd0, 1'b1, acc);
            drain();
            chk("subload_data", last_rdata, ld_exp[i]);
        end

        // byte store as read-modify-write
        preload(32'h300, 32'h1122_3344);
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h0000_00AA, 1'b1, acc);
        drain();
        chk("sb_latency", last_done_cyc - acc + 1, 32'd3);
        chk("sb_writes", wr_cnt - w0, 32'd1);
        chk("sb_addr", last_wa, 32'h300);
        chk("sb_merged", last_wd, 32'h1122_AA44);
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 1'b1, acc);
        drain();
        chk("sb_readback", last_rdata, 32'h1122_AA44);

        // misaligned / illegal requests
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(er_w[i], er_sz[i], 1'b0, er_a[i], 32'h0000_BBBB, 1'b1, acc);
            drain();
            chk("err_latency", last_done_cyc - acc + 1, 32'd1);
            chk("err_flag", {31'd0, last_err}, 32'd1);
            chk("err_rdata", last_rdata, 32'd0);
        end
        chk("err_writes", wr_cnt - w0, 32'd0);
        chk("err_mem100", mem[8'h40], 32'hDEAD_BEEF);
        chk("err_mem104", mem[8'h41], 32'd0);

        // reset during the read phase of a half store
        w0 = wr_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_5555, 1'b0, acc);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("rstmid_rw", {31'd0, mem_rw}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", {31'd0, ready}, 32'd1);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_err", {31'd0, err}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_maddr", mem_addr, 32'd0);
        chk("rstmid_mwdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        chk("rstmid_writes", wr_cnt - w0, 32'd0);
        chk("rstmid_mem", mem[8'hC0], 32'h1122_AA44);

        // back-to-back loads with req held high
        for (int i = 0; i < 4; i++) preload(32'h40 + 32'(4 * i), 32'hA0B0_C000 + 32'(i));
        done_cycs.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'b10, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 1'b1, accs[i]);
        end
        drain();
        chk("b2b_last", last_rdata, 32'hA0B0_C003);
        chk("b2b_count", done_cycs.size(), 32'd4);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_issue_gap", accs[i + 1] - accs[i], gap);
            if (done_cycs.size() == 4) chk("b2b_done_gap", done_cycs[i + 1] - done_cycs[i], gap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
